// File: rtl/dm_hart_agent.sv
// Hart-side park loop for the debug-memory SRAM port: halt announce, flag polling,
// WhereTo JAL decode, execution hand-off and the resume handshake.
module dm_hart_agent #(
   parameter int unsigned BusWidth      = 32,
   parameter int unsigned HartIdWidth   = 20,
   parameter int unsigned DmBaseAddress = 0,
   parameter int unsigned PollGap       = 0
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   debug_req_i,
   input  logic [HartIdWidth-1:0] hartid_i,
   input  logic                   exec_done_i,
   input  logic                   exception_i,
   output logic                   req_o,
   output logic                   we_o,
   output logic [BusWidth-1:0]    addr_o,
   output logic [BusWidth-1:0]    wdata_o,
   output logic [BusWidth/8-1:0]  be_o,
   input  logic [BusWidth-1:0]    rdata_i,
   output logic                   halted_o,
   output logic                   exec_valid_o,
   output logic [BusWidth-1:0]    exec_addr_o,
   output logic                   resume_o
);

   localparam int unsigned BeWidth  = BusWidth / 8;
   localparam int unsigned OffWidth = 12;
   localparam int unsigned CntWidth = (PollGap > 1) ? $clog2(PollGap) : 1;

   localparam logic [OffWidth-1:0] OffHalted    = 12'h100;
   localparam logic [OffWidth-1:0] OffGoing     = 12'h108;
   localparam logic [OffWidth-1:0] OffResuming  = 12'h110;
   localparam logic [OffWidth-1:0] OffException = 12'h118;
   localparam logic [OffWidth-1:0] OffWhereTo   = 12'h300;
   localparam logic [OffWidth-1:0] OffFlags     = 12'h400;
   localparam logic [OffWidth-1:0] OffResumeTgt = 12'h808;
   localparam logic [6:0]          OpcJal       = 7'h6f;

   typedef enum logic [3:0] {
      IDLE, HALT_WR, FLAG_RD, FLAG_WAIT, POLL_WAIT, GOING_WR,
      WT_RD, WT_WAIT, EXEC, EXC_WR, RESUME_WR
   } state_e;

   state_e                state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [BusWidth-1:0]   exec_addr_q, exec_addr_d;
   logic                  req_q, req_d;
   logic                  we_q, we_d;
   logic [BusWidth-1:0]   addr_q, addr_d;
   logic [BusWidth-1:0]   wdata_q, wdata_d;
   logic [BeWidth-1:0]    be_q, be_d;
   logic                  halted_q, halted_d;
   logic                  exec_valid_q, exec_valid_d;
   logic                  resume_q, resume_d;

   logic [7:0]            flag_c;
   logic [OffWidth-1:0]   flag_off_c;
   logic [OffWidth-1:0]   tgt_c;

   // Full bus address of a 12-bit debug-memory offset.
   function automatic logic [BusWidth-1:0] bus_addr(input logic [OffWidth-1:0] off);
      return BusWidth'(DmBaseAddress) + BusWidth'(off);
   endfunction

   // Flag byte of this hart, its containing word, and the JAL target (only imm[11:0] survives the 12-bit wrap).
   assign flag_c     = rdata_i[{hartid_i[1:0], 3'b000} +: 8];
   assign flag_off_c = OffFlags + OffWidth'({hartid_i[HartIdWidth-1:2], 2'b00});
   assign tgt_c      = OffWhereTo + {rdata_i[20], rdata_i[30:21], 1'b0};

   // Next-state logic and next values of the registered outputs.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      exec_addr_d  = exec_addr_q;
      req_d        = 1'b0;
      we_d         = 1'b0;
      addr_d       = '0;
      wdata_d      = '0;
      be_d         = '0;

      unique case (state_q)
         IDLE:      if (debug_req_i) state_d = HALT_WR;
         HALT_WR:   state_d = FLAG_RD;
         FLAG_RD:   state_d = FLAG_WAIT;
         FLAG_WAIT: begin
            if (flag_c[0])         state_d = GOING_WR;
            else if (flag_c[1])    state_d = RESUME_WR;
            else if (PollGap == 0) state_d = FLAG_RD;
            else begin
               state_d = POLL_WAIT;
               cnt_d   = '0;
            end
         end
         POLL_WAIT: begin
            if (cnt_q == CntWidth'(PollGap - 1)) state_d = FLAG_RD;
            else                                 cnt_d   = cnt_q + CntWidth'(1);
         end
         GOING_WR:  state_d = WT_RD;
         WT_RD:     state_d = WT_WAIT;
         WT_WAIT: begin
            if (rdata_i[6:0] != OpcJal)      state_d = EXC_WR;
            else if (tgt_c == OffResumeTgt)  state_d = RESUME_WR;
            else begin
               state_d     = EXEC;
               exec_addr_d = bus_addr(tgt_c);
            end
         end
         EXEC: begin
            if (exception_i)      state_d = EXC_WR;
            else if (exec_done_i) state_d = HALT_WR;
         end
         EXC_WR:    state_d = HALT_WR;
         RESUME_WR: state_d = IDLE;
         default:   state_d = IDLE;
      endcase

      // Bus access of the state being entered, so it is on the pins during that state's cycle.
      unique case (state_d)
         HALT_WR: begin
            req_d = 1'b1; we_d = 1'b1; addr_d = bus_addr(OffHalted);
            wdata_d = BusWidth'(hartid_i);
         end
         FLAG_RD: begin
            req_d = 1'b1; addr_d = bus_addr(flag_off_c);
         end
         GOING_WR: begin
            req_d = 1'b1; we_d = 1'b1; addr_d = bus_addr(OffGoing);
         end
         WT_RD: begin
            req_d = 1'b1; addr_d = bus_addr(OffWhereTo);
         end
         EXC_WR: begin
            req_d = 1'b1; we_d = 1'b1; addr_d = bus_addr(OffException);
         end
         RESUME_WR: begin
            req_d = 1'b1; we_d = 1'b1; addr_d = bus_addr(OffResuming);
            wdata_d = BusWidth'(hartid_i);
         end
         default: ;
      endcase

      if (we_d) be_d = '1;
      halted_d     = (state_d != IDLE);
      exec_valid_d = (state_d == EXEC);
      resume_d     = (state_d == RESUME_WR);
   end

   // State, poll counter and output registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         exec_addr_q  <= '0;
         req_q        <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         halted_q     <= 1'b0;
         exec_valid_q <= 1'b0;
         resume_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         exec_addr_q  <= exec_addr_d;
         req_q        <= req_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         halted_q     <= halted_d;
         exec_valid_q <= exec_valid_d;
         resume_q     <= resume_d;
      end
   end

   assign req_o        = req_q;
   assign we_o         = we_q;
   assign addr_o       = addr_q;
   assign wdata_o      = wdata_q;
   assign be_o         = be_q;
   assign halted_o     = halted_q;
   assign exec_valid_o = exec_valid_q;
   assign exec_addr_o  = exec_addr_q;
   assign resume_o     = resume_q;

endmodule

// File: tb/tb_dm_hart_agent.sv
// Bench for dm_hart_agent: a debug-memory responder plus directed and random park-loop sessions.
module tb_dm_hart_agent;

   localparam int unsigned BusWidth    = 32;
   localparam int unsigned HartIdWidth = 20;
   localparam int unsigned DmBase      = 32'h0001_0000;

   logic                   clk_i = 1'b0;
   logic                   rst_ni = 1'b0;
   logic                   debug_req_i = 1'b0;
   logic [HartIdWidth-1:0] hartid_i = '0;
   logic                   exec_done_i = 1'b0;
   logic                   exception_i = 1'b0;
   logic                   req_o, we_o, halted_o, exec_valid_o, resume_o;
   logic [BusWidth-1:0]    addr_o, wdata_o, exec_addr_o;
   logic [BusWidth-1:0]    rdata_i = '0;
   logic [BusWidth/8-1:0]  be_o;

   logic [31:0] mem [0:4095];
   int n_checks = 0;
   int n_fail   = 0;

   dm_hart_agent #(
      .BusWidth(BusWidth), .HartIdWidth(HartIdWidth), .DmBaseAddress(DmBase), .PollGap(0)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .debug_req_i(debug_req_i), .hartid_i(hartid_i),
      .exec_done_i(exec_done_i), .exception_i(exception_i), .req_o(req_o), .we_o(we_o),
      .addr_o(addr_o), .wdata_o(wdata_o), .be_o(be_o), .rdata_i(rdata_i), .halted_o(halted_o),
      .exec_valid_o(exec_valid_o), .exec_addr_o(exec_addr_o), .resume_o(resume_o)
   );

   always #5 clk_i = ~clk_i;

   // Debug memory: read data appears the cycle after the read strobe; other cycles carry garbage.
   always @(posedge clk_i) begin
      if (req_o && !we_o) rdata_i <= mem[addr_o[11:0]];
      else                rdata_i <= $urandom();
   end

   task automatic step();
      @(negedge clk_i);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: flag word offset, flag byte, and JAL target decoded arithmetically (-1 if not a JAL).
   function automatic logic [11:0] flag_off(input logic [HartIdWidth-1:0] h);
      return 12'((1024 + (int'(h) / 4) * 4) % 4096);
   endfunction

   function automatic int jal_target(input logic [31:0] ins);
      int imm;
      if (ins[6:0] != 7'h6f) return -1;
      imm = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12)
          + int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
      if (ins[31]) imm = imm - (1 << 21);
      return ((768 + imm) % 4096 + 4096) % 4096;
   endfunction

   task automatic chk_wr(input string tag, input int off, input logic [31:0] wd);
      chk({tag, ".req"}, 64'(req_o), 64'(1));
      chk({tag, ".we"}, 64'(we_o), 64'(1));
      chk({tag, ".addr"}, 64'(addr_o), 64'(32'(DmBase + off)));
      chk({tag, ".wdata"}, 64'(wdata_o), 64'(wd));
      chk({tag, ".be"}, 64'(be_o), 64'(4'hf));
   endtask

   task automatic chk_rd(input string tag, input int off);
      chk({tag, ".req"}, 64'(req_o), 64'(1));
      chk({tag, ".we"}, 64'(we_o), 64'(0));
      chk({tag, ".addr"}, 64'(addr_o), 64'(32'(DmBase + off)));
   endtask

   task automatic expect_halt_wr();
      chk_wr("halt_wr", 'h100, 32'(hartid_i));
      chk("halt_wr.halted", 64'(halted_o), 64'(1));
      chk("halt_wr.exec_valid", 64'(exec_valid_o), 64'(0));
   endtask

   // Current cycle is the resume write; the following cycle must be idle.
   task automatic expect_resume();
      chk_wr("resume_wr", 'h110, 32'(hartid_i));
      chk("resume_wr.resume", 64'(resume_o), 64'(1));
      chk("resume_wr.halted", 64'(halted_o), 64'(1));
      step();
      chk("idle.halted", 64'(halted_o), 64'(0));
      chk("idle.resume", 64'(resume_o), 64'(0));
      chk("idle.req", 64'(req_o), 64'(0));
   endtask

   // Called the cycle before a flag read; places the flag byte among random neighbours.
   task automatic poll_once(input logic [7:0] flag);
      logic [31:0] w;
      int sh;
      w  = $urandom();
      sh = int'(hartid_i[1:0]);
      w[sh*8 +: 8] = flag;
      mem[flag_off(hartid_i)] = w;
      step();
      chk_rd("flag_rd", int'(flag_off(hartid_i)));
      chk("flag_rd.halted", 64'(halted_o), 64'(1));
      step();
      chk("flag_wait.req", 64'(req_o), 64'(0));
   endtask

   // Called in the flag-data cycle of a go decision; res: 0 exec, 1 exception write, 2 resumed.
   task automatic go_path(input logic [31:0] ins, output int res);
      int tgt;
      mem[12'h300] = ins;
      tgt = jal_target(ins);
      step(); chk_wr("going_wr", 'h108, 32'h0);
      step(); chk_rd("wt_rd", 'h300);
      step();
      chk("wt_wait.req", 64'(req_o), 64'(0));
      chk("wt_wait.exec_valid", 64'(exec_valid_o), 64'(0));
      step();
      if (tgt < 0) begin
         chk_wr("exc_wr", 'h118, 32'h0);
         res = 1;
      end else if (tgt == 'h808) begin
         expect_resume();
         res = 2;
      end else begin
         chk("exec.valid", 64'(exec_valid_o), 64'(1));
         chk("exec.addr", 64'(exec_addr_o), 64'(32'(DmBase + tgt)));
         chk("exec.req", 64'(req_o), 64'(0));
         res = 0;
      end
   endtask

   task automatic random_session(input int rounds);
      int res, np, kind, nw;
      logic [7:0] f;
      logic [31:0] r, ins;
      hartid_i = HartIdWidth'($urandom());
      debug_req_i = 1'b1;
      step();
      debug_req_i = 1'b0;
      expect_halt_wr();
      for (int k = 0; k < rounds; k++) begin
         np = $urandom_range(2, 0);
         for (int p = 0; p < np; p++) poll_once(8'($urandom()) & 8'hfc);
         if (k == rounds - 1) f = 8'h02 | (8'($urandom()) & 8'hfc);
         else                 f = 8'h01 | (8'($urandom()) & 8'hfe);
         poll_once(f);
         if (!f[0]) begin
            step();
            expect_resume();
            return;
         end
         r = $urandom();
         kind = $urandom_range(3, 0);
         if (kind <= 1)      ins = {r[31:12], r[11:7], 7'h6f};
         else if (kind == 2) ins = {r[31:7], (r[6:0] == 7'h6f) ? 7'h13 : r[6:0]};
         else                ins = {r[31], 10'h284, 1'b0, r[19:12], r[11:7], 7'h6f};
         go_path(ins, res);
         if (res == 2) return;
         if (res == 0) begin
            nw = $urandom_range(3, 0);
            for (int i = 0; i < nw; i++) begin
               step();
               chk("exec_hold.valid", 64'(exec_valid_o), 64'(1));
               chk("exec_hold.req", 64'(req_o), 64'(0));
            end
            kind = $urandom_range(2, 0);
            exec_done_i = (kind != 1);
            exception_i = (kind != 0);
            step();
            exec_done_i = 1'b0;
            exception_i = 1'b0;
            if (kind != 0) begin
               chk_wr("exec_exc_wr", 'h118, 32'h0);
               step();
            end
         end else begin
            step();
         end
         expect_halt_wr();
      end
   endtask

   initial begin
      int res;
      for (int i = 0; i < 4096; i++) mem[i] = '0;

      // Reset state
      step(); step();
      chk("rst.req", 64'(req_o), 64'(0));
      chk("rst.we", 64'(we_o), 64'(0));
      chk("rst.addr", 64'(addr_o), 64'(0));
      chk("rst.wdata", 64'(wdata_o), 64'(0));
      chk("rst.be", 64'(be_o), 64'(0));
      chk("rst.halted", 64'(halted_o), 64'(0));
      chk("rst.exec_valid", 64'(exec_valid_o), 64'(0));
      chk("rst.exec_addr", 64'(exec_addr_o), 64'(0));
      chk("rst.resume", 64'(resume_o), 64'(0));
      rst_ni = 1'b1;
      step();
      chk("idle.req", 64'(req_o), 64'(0));

      // Halt, two empty back-to-back polls, go to a program-buffer target
      hartid_i = HartIdWidth'(3);
      debug_req_i = 1'b1;
      step();
      debug_req_i = 1'b0;
      expect_halt_wr();
      poll_once(8'h00);
      poll_once(8'h00);
      poll_once(8'h01);
      go_path(32'h0600_006f, res);
      chk("t2.res", 64'(res), 64'(0));

      // Exec done returns to the halted write, exec target held afterwards
      exec_done_i = 1'b1;
      step();
      exec_done_i = 1'b0;
      expect_halt_wr();
      chk("t3.exec_addr_hold", 64'(exec_addr_o), 64'(DmBase + 'h360));
      poll_once(8'h00);

      // Both go and resume set: go wins; exception beats done in the same cycle
      poll_once(8'h03);
      go_path(32'h0000_006f, res);
      chk("t5.res", 64'(res), 64'(0));
      exception_i = 1'b1;
      exec_done_i = 1'b1;
      step();
      exception_i = 1'b0;
      exec_done_i = 1'b0;
      chk_wr("t4.exc_wr", 'h118, 32'h0);
      step();
      expect_halt_wr();
      poll_once(8'h00);
      poll_once(8'h02);
      step();
      expect_resume();

      // Randomized sessions
      for (int s = 0; s < 25; s++) random_session(int'($urandom_range(4, 1)));

      // Non-JAL WhereTo, then asynchronous reset while waiting on flag data
      hartid_i = HartIdWidth'(3);
      debug_req_i = 1'b1;
      step();
      debug_req_i = 1'b0;
      expect_halt_wr();
      poll_once(8'h01);
      go_path(32'h0000_0013, res);
      chk("t6.res", 64'(res), 64'(1));
      step();
      expect_halt_wr();
      poll_once(8'h00);
      rst_ni = 1'b0;
      #1;
      chk("t6.rst.req", 64'(req_o), 64'(0));
      chk("t6.rst.halted", 64'(halted_o), 64'(0));
      chk("t6.rst.exec_valid", 64'(exec_valid_o), 64'(0));
      debug_req_i = 1'b1;
      step();
      rst_ni = 1'b1;
      step();
      debug_req_i = 1'b0;
      expect_halt_wr();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
